// File: rtl/ula_scheduler.sv
// ula_scheduler
// Time-shares one combinational ULA between two requesters. A request is
// captured in IDLE (round-robin on a tie), the ULA is given one full cycle in
// EXEC, and the registered result is returned with a one-cycle ack in DONE.
//
// Ports
//   clk, reset                 rising-edge clock, async active-high reset
//   req0/1, srcA0/1, srcB0/1,  level requests with their operands and
//   ctl0/1                     ULA operation codes
//   ack0, ack1                 one-cycle response strobe to the winner
//   rsp_result, rsp_zero,      registered result, zero flag and
//   rsp_err                    illegal-code flag (valid with ack)
//   busy                       high in EXEC and DONE
//   ula_srcA/B, ula_control    operand bus to the ULA
//   ula_result, ula_z          ULA result and zero flag
//
// state | meaning
// IDLE  | waiting; captures the winning request's operands
// EXEC  | ULA evaluates the held operands; result registered at exit
// DONE  | ack to the granted requester; round-robin pointer updated at exit
module ula_scheduler (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [7:0]  srcA0,
  input  logic [7:0]  srcA1,
  input  logic [15:0] srcB0,
  input  logic [15:0] srcB1,
  input  logic [2:0]  ctl0,
  input  logic [2:0]  ctl1,
  output logic        ack0,
  output logic        ack1,
  output logic [7:0]  rsp_result,
  output logic        rsp_zero,
  output logic        rsp_err,
  output logic        busy,
  output logic [7:0]  ula_srcA,
  output logic [15:0] ula_srcB,
  output logic [2:0]  ula_control,
  input  logic [7:0]  ula_result,
  input  logic        ula_z
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        grant_q, grant_d;
  logic [7:0]  opa_q, opa_d;
  logic [15:0] opb_q, opb_d;
  logic [2:0]  ctl_q, ctl_d;
  logic [7:0]  res_q, res_d;
  logic        zero_q, zero_d;
  logic        err_q, err_d;
  logic        rsp_err_q, rsp_err_d;

  logic        winner;
  logic [2:0]  sel_ctl;

  // On a tie the requester that was not served last wins.
  always_comb begin
    winner  = (req0 & req1) ? ~last_q : req1;
    sel_ctl = winner ? ctl1 : ctl0;
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    ctl_d     = ctl_q;
    res_d     = res_q;
    zero_d    = zero_q;
    err_d     = err_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          grant_d = winner;
          opa_d   = winner ? srcA1 : srcA0;
          opb_d   = winner ? srcB1 : srcB0;
          ctl_d   = sel_ctl;
          // codes 4 and 5 are the only ones with [2:1] == 2'b10
          err_d   = (sel_ctl[2:1] == 2'b10);
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d     = err_q ? 8'h00 : ula_result;
        zero_d    = ~err_q & ula_z;
        // separate copy so rsp_err holds while the next request is captured
        rsp_err_d = err_q;
        state_d   = DONE;
      end
      DONE: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      grant_q   <= 1'b0;
      opa_q     <= 8'h00;
      opb_q     <= 16'h0000;
      ctl_q     <= 3'd0;
      res_q     <= 8'h00;
      zero_q    <= 1'b0;
      err_q     <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      ctl_q     <= ctl_d;
      res_q     <= res_d;
      zero_q    <= zero_d;
      err_q     <= err_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign ack0        = (state_q == DONE) & ~grant_q;
  assign ack1        = (state_q == DONE) & grant_q;
  assign busy        = (state_q != IDLE);
  assign rsp_result  = res_q;
  assign rsp_zero    = zero_q;
  assign rsp_err     = rsp_err_q;
  assign ula_srcA    = opa_q;
  assign ula_srcB    = opb_q;
  assign ula_control = ctl_q;

endmodule

// File: tb/tb_ula_scheduler.sv
// Bench for ula_scheduler: a behavioural ULA drives ula_result/ula_z, a
// transaction-level model predicts acks, busy and responses every cycle, and
// directed phases pin the model with literal values.
module tb_ula_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [7:0]  srcA0 = '0, srcA1 = '0;
  logic [15:0] srcB0 = '0, srcB1 = '0;
  logic [2:0]  ctl0 = '0, ctl1 = '0;
  logic        ack0, ack1, rsp_zero, rsp_err, busy;
  logic [7:0]  rsp_result, ula_srcA;
  logic [15:0] ula_srcB;
  logic [2:0]  ula_control;
  logic [7:0]  ula_result;
  logic        ula_z;

  int total = 0;
  int bad = 0;

  ula_scheduler dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .srcA0(srcA0), .srcA1(srcA1),
    .srcB0(srcB0), .srcB1(srcB1),
    .ctl0(ctl0), .ctl1(ctl1),
    .ack0(ack0), .ack1(ack1),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .busy(busy),
    .ula_srcA(ula_srcA), .ula_srcB(ula_srcB), .ula_control(ula_control),
    .ula_result(ula_result), .ula_z(ula_z)
  );

  always #5 clk = ~clk;

  // Behavioural ULA. Undefined codes return junk so masking is observable.
  function automatic logic [7:0] ula_fn(input logic [7:0] a, input logic [15:0] b,
                                        input logic [2:0] c);
    case (c)
      3'd0: return a & b[7:0];
      3'd1: return a | b[7:0];
      3'd2: return a + b[7:0];
      3'd3: return a >> b[10:6];
      3'd6: return a - b[7:0];
      3'd7: return (a < b[7:0]) ? 8'h01 : 8'h00;
      default: return 8'hA5;
    endcase
  endfunction

  always_comb begin
    ula_result = ula_fn(ula_srcA, ula_srcB, ula_control);
    ula_z = (ula_control == 3'd4 || ula_control == 3'd5) ? 1'b1 : (ula_result == 8'h00);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a grant at edge g gives busy after g and g+1, ack
  // after g+1, and the next grant no earlier than edge g+3.
  int          e = 0;
  bit          op_v = 0;
  int          g_edge = 0;
  bit          g_who = 0;
  bit          m_last = 1;
  logic [7:0]  m_a = '0;
  logic [15:0] m_b = '0;
  logic [2:0]  m_c = '0;
  logic [7:0]  m_res = '0;
  bit          m_zero = 0, m_err = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      op_v = 0; m_last = 1; m_a = '0; m_b = '0; m_c = '0;
    end else begin
      e++;
      if (!op_v) begin
        if (req0 || req1) begin
          g_who = (req0 && req1) ? !m_last : req1;
          m_a = g_who ? srcA1 : srcA0;
          m_b = g_who ? srcB1 : srcB0;
          m_c = g_who ? ctl1 : ctl0;
          m_err = (m_c == 3'd4 || m_c == 3'd5);
          m_res = m_err ? 8'h00 : ula_fn(m_a, m_b, m_c);
          m_zero = !m_err && (m_res == 8'h00);
          op_v = 1;
          g_edge = e;
        end
      end else if (e == g_edge + 2) begin
        m_last = g_who;
        op_v = 0;
      end
    end
  end

  always @(negedge clk) begin
    bit ex_ack;
    ex_ack = op_v && (e == g_edge + 1);
    chk("ack0", ack0, ex_ack && !g_who);
    chk("ack1", ack1, ex_ack && g_who);
    chk("busy", busy, op_v);
    chk("ula_srcA", ula_srcA, m_a);
    chk("ula_srcB", ula_srcB, m_b);
    chk("ula_control", ula_control, m_c);
    if (ex_ack) begin
      chk("rsp_result", rsp_result, m_res);
      chk("rsp_zero", rsp_zero, m_zero);
      chk("rsp_err", rsp_err, m_err);
    end
  end

  task automatic wait_ack(output int n, output bit who);
    bit ok;
    ok = 0; n = 0; who = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (ack0 || ack1) begin
        who = ack1;
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL ack_timeout: got no ack expected ack within 20 cycles");
    end
  endtask

  initial begin
    int n;
    bit who;

    // Reset state, with both requesters already holding a tie.
    req0 = 1; srcA0 = 8'h01; srcB0 = 16'h0001; ctl0 = 3'd2;
    req1 = 1; srcA1 = 8'h80; srcB1 = 16'h00C0; ctl1 = 3'd3;
    @(negedge clk); @(negedge clk);
    chk("reset_ack0", ack0, 0);
    chk("reset_ack1", ack1, 0);
    chk("reset_busy", busy, 0);
    chk("reset_result", rsp_result, 8'h00);
    chk("reset_srcB", ula_srcB, 16'h0000);
    #2 reset = 0;

    // Tie and fairness: 0,1,0 spaced three cycles apart.
    wait_ack(n, who);
    chk("tie1_lat", n, 2); chk("tie1_who", who, 0); chk("tie1_res", rsp_result, 8'h02);
    wait_ack(n, who);
    chk("tie2_gap", n, 3); chk("tie2_who", who, 1); chk("tie2_res", rsp_result, 8'h10);
    wait_ack(n, who);
    chk("tie3_gap", n, 3); chk("tie3_who", who, 0); chk("tie3_res", rsp_result, 8'h02);
    #2 req0 = 0; req1 = 0;
    @(negedge clk); @(negedge clk);

    // Single request ADD 0x0F + 1.
    #2 req0 = 1; srcA0 = 8'h0F; srcB0 = 16'h0001; ctl0 = 3'd2;
    wait_ack(n, who);
    chk("add_lat", n, 2); chk("add_who", who, 0);
    chk("add_res", rsp_result, 8'h10); chk("add_zero", rsp_zero, 0); chk("add_err", rsp_err, 0);
    #2 req0 = 0;
    @(negedge clk);

    // SUB to zero on requester 1.
    #2 req1 = 1; srcA1 = 8'h2A; srcB1 = 16'h002A; ctl1 = 3'd6;
    wait_ack(n, who);
    chk("sub_who", who, 1); chk("sub_res", rsp_result, 8'h00); chk("sub_zero", rsp_zero, 1);
    #2 req1 = 0;
    @(negedge clk);

    // Illegal code, then a legal SLT.
    #2 req0 = 1; srcA0 = 8'h33; srcB0 = 16'h0000; ctl0 = 3'd5;
    wait_ack(n, who);
    chk("ill_who", who, 0); chk("ill_err", rsp_err, 1);
    chk("ill_res", rsp_result, 8'h00); chk("ill_zero", rsp_zero, 0);
    #2 srcA0 = 8'h03; srcB0 = 16'h0007; ctl0 = 3'd7;
    wait_ack(n, who);
    chk("slt_gap", n, 3); chk("slt_res", rsp_result, 8'h01); chk("slt_err", rsp_err, 0);
    #2 req0 = 0;
    @(negedge clk);

    // Reset during EXEC of a requester-1 AND.
    #2 req1 = 1; srcA1 = 8'hF3; srcB1 = 16'h003C; ctl1 = 3'd0;
    @(negedge clk);
    chk("mid_busy_before", busy, 1);
    #1 reset = 1;
    #1;
    chk("mid_ack1", ack1, 0); chk("mid_busy", busy, 0);
    chk("mid_result", rsp_result, 8'h00); chk("mid_srcA", ula_srcA, 8'h00);
    chk("mid_ctl", ula_control, 3'd0);
    @(negedge clk);
    #2 reset = 0;
    wait_ack(n, who);
    chk("regrant_lat", n, 2); chk("regrant_who", who, 1);
    chk("regrant_res", rsp_result, 8'h30);
    #2 req1 = 0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
